filtro_teclas: RTL and testbench
================================

Name: filtro_teclas

Overview:
- Input conditioning stage for the push-button keys, sitting directly upstream of the display counters.
- Synchronises and debounces each active-low KEY line on the board.
- Produces clean one-cycle press, release and auto-repeat strobes, so the counter advances or clears on a strobe instead of sampling raw buttons.
- Debounce and repeat timing are measured in clock cycles (50 MHz nominal).

Parameters:
- N_KEYS, 4: number of independent key channels.
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz); minimum 2.
- REPEAT_DELAY, 25000000: cycles from the press strobe to the first repeat strobe (500 ms).
- REPEAT_RATE, 5000000: cycles between subsequent repeat strobes (100 ms); minimum 2.
- KEY_ACTIVE_LOW, 1: 1 means KEY=0 is pressed; 0 means KEY=1 is pressed.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- KEY  input  N_KEYS  raw, asynchronous button levels.
- REPEAT_EN  input  N_KEYS  per-key auto-repeat enable; synchronous, sampled each cycle.
- PRESSED  output  N_KEYS  debounced level; 1 while the key is accepted as held.
- PRESS_PULSE  output  N_KEYS  one-cycle strobe on an accepted press.
- RELEASE_PULSE  output  N_KEYS  one-cycle strobe on an accepted release.
- REPEAT_PULSE  output  N_KEYS  one-cycle auto-repeat strobe.
- STEP  output  N_KEYS  PRESS_PULSE OR REPEAT_PULSE, registered identically to both.

Behaviour:
- Reset (async assert; release takes effect on the next CLK edge):
  - All outputs are 0 and every channel's FSM is in RELEASED.
  - Debounce and repeat counters are 0.
  - Both synchroniser flops load the released level.
  - Consequence: a key held through reset is debounced and reported as a new press after reset.
- Synchroniser: two flops per key. The raw level is inverted when KEY_ACTIVE_LOW=1, so internal s=1 means pressed. Latency from KEY to s is 2 cycles.
- Per-key FSM, independent per channel:
  - RELEASED: PRESSED=0. If s=1, load cnt=1 and go to CONFIRM_PRESS.
  - CONFIRM_PRESS: if s=0, cnt=0 and return to RELEASED, with no strobe. Otherwise, if cnt==DEBOUNCE_CYCLES-1, go to HELD, set PRESSED=1, and assert PRESS_PULSE and STEP for exactly that cycle. Otherwise cnt+1.
  - HELD: if s=0, load cnt=1 and go to CONFIRM_RELEASE, keeping PRESSED=1. The repeat timer runs only in HELD.
  - CONFIRM_RELEASE: if s=1, return to HELD with no strobe. The repeat timer is not reset, but it is frozen while in CONFIRM_RELEASE. If cnt==DEBOUNCE_CYCLES-1, go to RELEASED, clear PRESSED, and pulse RELEASE_PULSE. Otherwise cnt+1.
- Press latency: the s change must hold DEBOUNCE_CYCLES consecutive cycles. PRESSED rises DEBOUNCE_CYCLES+2 edges after a clean KEY edge.
- Auto-repeat:
  - rcnt is cleared on the PRESS_PULSE cycle, then increments each HELD cycle while REPEAT_EN[i]=1.
  - First REPEAT_PULSE when rcnt reaches REPEAT_DELAY; afterwards rcnt reloads so that pulses occur every REPEAT_RATE cycles.
  - REPEAT_EN[i]=0 clears rcnt and suppresses REPEAT_PULSE. Re-enabling while held restarts from the full REPEAT_DELAY.
  - PRESS_PULSE and REPEAT_PULSE are never high in the same cycle.
- Width rules:
  - Counter width: ceil(log2(max of DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)) + 1.
  - Counters saturate and never wrap.
- Simultaneous events: channels share no state, so any combination of strobes across keys may occur in one cycle.
- Reset mid-debounce or mid-repeat aborts immediately, and no pulse is emitted.

Test Plan (bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, KEY_ACTIVE_LOW=1):
- Clean press: KEY[0] 1->0 and held -> PRESSED[0] rises 6 edges later; PRESS_PULSE[0] and STEP[0] high for exactly 1 cycle; other bits stay 0.
- Bounce rejection: KEY[1] low for 3 cycles, high for 1, low for 3, then high -> no strobes; PRESSED[1] stays 0 throughout.
- Release: KEY[0] held, then 0->1 with one 2-cycle glitch back to 0 -> PRESSED[0] falls only after 4 stable released cycles; exactly 1 RELEASE_PULSE[0].
- Auto-repeat: REPEAT_EN[2]=1, KEY[2] held for 30 cycles after PRESS_PULSE -> REPEAT_PULSE[2] at +10, +13, +16, ..., +28 (7 pulses); STEP[2] shows 8 pulses total.
- Repeat disable: as above, but REPEAT_EN[2] drops at +12 and rises at +20 -> pulses at +10, then +30; no pulse in between.
- Reset: RST pulsed during CONFIRM_PRESS and again during HELD with KEY still low -> all outputs 0 immediately; after RST deasserts, PRESSED rises 6 edges later with one fresh PRESS_PULSE.

Source files
------------

// File: rtl/filtro_teclas.sv
`timescale 1ns/1ps
// Key conditioning: two-flop synchroniser, per-key debounce FSM and auto-repeat
// timer, producing registered level, press/release/repeat strobes and STEP.
module filtro_teclas #(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_KEYS-1:0] KEY,
  input  logic [N_KEYS-1:0] REPEAT_EN,
  output logic [N_KEYS-1:0] PRESSED,
  output logic [N_KEYS-1:0] PRESS_PULSE,
  output logic [N_KEYS-1:0] RELEASE_PULSE,
  output logic [N_KEYS-1:0] REPEAT_PULSE,
  output logic [N_KEYS-1:0] STEP
);

  localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CYC = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DELAY_T  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RATE_T   = CW'(REPEAT_RATE);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    HELD            = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } key_state_e;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    if (v == CNT_MAX) sat_inc = v;
    else              sat_inc = v + CNT_ONE;
  endfunction

  logic [N_KEYS-1:0] key_lvl_s;
  logic [N_KEYS-1:0] sync1_r, sync2_r;

  key_state_e        state_r   [N_KEYS];
  key_state_e        state_nx_s[N_KEYS];
  logic [CW-1:0]     cnt_r     [N_KEYS];
  logic [CW-1:0]     cnt_nx_s  [N_KEYS];
  logic [CW-1:0]     rcnt_r    [N_KEYS];
  logic [CW-1:0]     rcnt_nx_s [N_KEYS];
  logic [N_KEYS-1:0] rfirst_r, rfirst_nx_s;

  logic [N_KEYS-1:0] pressed_r, press_r, release_r, repeat_r, step_r;
  logic [N_KEYS-1:0] pressed_nx_s, press_nx_s, release_nx_s, repeat_nx_s;

  // Internal polarity: 1 means pressed regardless of board wiring.
  assign key_lvl_s = KEY_ACTIVE_LOW ? ~KEY : KEY;

  // Two-flop synchroniser; reset loads the released level.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_r <= {N_KEYS{1'b0}};
      sync2_r <= {N_KEYS{1'b0}};
    end else begin
      sync1_r <= key_lvl_s;
      sync2_r <= sync1_r;
    end
  end

  // Per-key debounce FSM and repeat timer next-state logic.
  always_comb begin
    pressed_nx_s = pressed_r;
    press_nx_s   = {N_KEYS{1'b0}};
    release_nx_s = {N_KEYS{1'b0}};
    repeat_nx_s  = {N_KEYS{1'b0}};
    rfirst_nx_s  = rfirst_r;
    for (int i = 0; i < N_KEYS; i++) begin
      state_nx_s[i] = state_r[i];
      cnt_nx_s[i]   = cnt_r[i];
      rcnt_nx_s[i]  = rcnt_r[i];
      case (state_r[i])
        RELEASED: begin
          pressed_nx_s[i] = 1'b0;
          if (sync2_r[i]) begin
            state_nx_s[i] = CONFIRM_PRESS;
            cnt_nx_s[i]   = CNT_ONE;
          end else begin
            cnt_nx_s[i]   = CNT_ZERO;
          end
        end
        CONFIRM_PRESS: begin
          if (!sync2_r[i]) begin
            state_nx_s[i] = RELEASED;
            cnt_nx_s[i]   = CNT_ZERO;
          end else if (cnt_r[i] == DEB_LAST) begin
            state_nx_s[i]   = HELD;
            cnt_nx_s[i]     = CNT_ZERO;
            pressed_nx_s[i] = 1'b1;
            press_nx_s[i]   = 1'b1;
            rcnt_nx_s[i]    = CNT_ZERO;
            rfirst_nx_s[i]  = 1'b0;
          end else begin
            cnt_nx_s[i]     = sat_inc(cnt_r[i]);
          end
        end
        HELD: begin
          pressed_nx_s[i] = 1'b1;
          if (!sync2_r[i]) begin
            state_nx_s[i] = CONFIRM_RELEASE;
            cnt_nx_s[i]   = CNT_ONE;
          end else if (!REPEAT_EN[i]) begin
            rcnt_nx_s[i]   = CNT_ZERO;
            rfirst_nx_s[i] = 1'b0;
          end else if (sat_inc(rcnt_r[i]) == (rfirst_r[i] ? RATE_T : DELAY_T)) begin
            // First period is REPEAT_DELAY, every later one REPEAT_RATE.
            repeat_nx_s[i] = 1'b1;
            rcnt_nx_s[i]   = CNT_ZERO;
            rfirst_nx_s[i] = 1'b1;
          end else begin
            rcnt_nx_s[i]   = sat_inc(rcnt_r[i]);
          end
        end
        CONFIRM_RELEASE: begin
          pressed_nx_s[i] = 1'b1;
          if (!REPEAT_EN[i]) begin
            rcnt_nx_s[i]   = CNT_ZERO;
            rfirst_nx_s[i] = 1'b0;
          end else begin
            rcnt_nx_s[i]   = rcnt_r[i];
          end
          if (sync2_r[i]) begin
            state_nx_s[i] = HELD;
            cnt_nx_s[i]   = CNT_ZERO;
          end else if (cnt_r[i] == DEB_LAST) begin
            state_nx_s[i]   = RELEASED;
            cnt_nx_s[i]     = CNT_ZERO;
            pressed_nx_s[i] = 1'b0;
            release_nx_s[i] = 1'b1;
          end else begin
            cnt_nx_s[i]     = sat_inc(cnt_r[i]);
          end
        end
        default: begin
          state_nx_s[i]   = RELEASED;
          cnt_nx_s[i]     = CNT_ZERO;
          rcnt_nx_s[i]    = CNT_ZERO;
          rfirst_nx_s[i]  = 1'b0;
          pressed_nx_s[i] = 1'b0;
        end
      endcase
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_r[i] <= RELEASED;
        cnt_r[i]   <= CNT_ZERO;
        rcnt_r[i]  <= CNT_ZERO;
      end
      rfirst_r  <= {N_KEYS{1'b0}};
      pressed_r <= {N_KEYS{1'b0}};
      press_r   <= {N_KEYS{1'b0}};
      release_r <= {N_KEYS{1'b0}};
      repeat_r  <= {N_KEYS{1'b0}};
      step_r    <= {N_KEYS{1'b0}};
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_r[i] <= state_nx_s[i];
        cnt_r[i]   <= cnt_nx_s[i];
        rcnt_r[i]  <= rcnt_nx_s[i];
      end
      rfirst_r  <= rfirst_nx_s;
      pressed_r <= pressed_nx_s;
      press_r   <= press_nx_s;
      release_r <= release_nx_s;
      repeat_r  <= repeat_nx_s;
      step_r    <= press_nx_s | repeat_nx_s;
    end
  end

  assign PRESSED       = pressed_r;
  assign PRESS_PULSE   = press_r;
  assign RELEASE_PULSE = release_r;
  assign REPEAT_PULSE  = repeat_r;
  assign STEP          = step_r;

endmodule

// File: tb/tb_filtro_teclas.sv
`timescale 1ns/1ps
// Directed bench for filtro_teclas with short debounce/repeat timing.
module tb_filtro_teclas;

  logic       CLK;
  logic       RST;
  logic [3:0] KEY;
  logic [3:0] REPEAT_EN;
  logic [3:0] PRESSED, PRESS_PULSE, RELEASE_PULSE, REPEAT_PULSE, STEP;

  int checks = 0;
  int errors = 0;
  int rep_cnt;
  int step_cnt;
  int rel_cnt;

  filtro_teclas #(
    .N_KEYS(4), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .CLK(CLK), .RST(RST), .KEY(KEY), .REPEAT_EN(REPEAT_EN),
    .PRESSED(PRESSED), .PRESS_PULSE(PRESS_PULSE), .RELEASE_PULSE(RELEASE_PULSE),
    .REPEAT_PULSE(REPEAT_PULSE), .STEP(STEP)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] pr, input logic [3:0] pp,
                         input logic [3:0] rl, input logic [3:0] rp, input logic [3:0] st);
    chk({tag, " PRESSED"}, PRESSED, pr);
    chk({tag, " PRESS_PULSE"}, PRESS_PULSE, pp);
    chk({tag, " RELEASE_PULSE"}, RELEASE_PULSE, rl);
    chk({tag, " REPEAT_PULSE"}, REPEAT_PULSE, rp);
    chk({tag, " STEP"}, STEP, st);
  endtask

  initial begin
    RST = 1'b1;
    KEY = 4'hF;
    REPEAT_EN = 4'h0;
    tick();
    tick();
    chk_all("reset", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    RST = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_all($sformatf("idle k=%0d", k), 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    end

    // Clean press on key 0: PRESSED after 6 edges, one-cycle strobe.
    KEY[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_all($sformatf("press k=%0d", k), (k >= 6) ? 4'b0001 : 4'b0000,
              (k == 6) ? 4'b0001 : 4'b0000, 4'h0, 4'h0, (k == 6) ? 4'b0001 : 4'b0000);
    end

    // Bounce on key 1: two 3-cycle lows never reach 4 stable cycles.
    KEY[1] = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk_all($sformatf("bounce k=%0d", k), 4'b0001, 4'h0, 4'h0, 4'h0, 4'h0);
      if (k == 3) KEY[1] = 1'b0;
      if (k == 3) KEY[1] = 1'b1;
      if (k == 4) KEY[1] = 1'b0;
      if (k == 7) KEY[1] = 1'b1;
    end

    // Release key 0 with a 2-cycle glitch back to pressed.
    rel_cnt = 0;
    KEY[0] = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (RELEASE_PULSE[0]) rel_cnt++;
      chk_all($sformatf("release k=%0d", k), (k < 10) ? 4'b0001 : 4'b0000, 4'h0,
              (k == 10) ? 4'b0001 : 4'b0000, 4'h0, 4'h0);
      if (k == 2) KEY[0] = 1'b0;
      if (k == 4) KEY[0] = 1'b1;
    end
    chk("release pulse count", 4'(rel_cnt), 4'd1);

    // Auto-repeat on key 2: pulses at +10,+13,...,+28.
    REPEAT_EN = 4'b0100;
    KEY[2] = 1'b0;
    rep_cnt = 0;
    step_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (STEP[2]) step_cnt++;
      chk_all($sformatf("rep press k=%0d", k), (k >= 6) ? 4'b0100 : 4'b0000,
              (k == 6) ? 4'b0100 : 4'b0000, 4'h0, 4'h0, (k == 6) ? 4'b0100 : 4'b0000);
    end
    for (int j = 1; j <= 36; j++) begin
      logic rp;
      tick();
      rp = (j >= 10) && (j <= 28) && (((j - 10) % 3) == 0);
      if (REPEAT_PULSE[2]) rep_cnt++;
      if (STEP[2]) step_cnt++;
      chk_all($sformatf("repeat j=%0d", j), (j < 33) ? 4'b0100 : 4'b0000, 4'h0,
              (j == 33) ? 4'b0100 : 4'b0000, rp ? 4'b0100 : 4'b0000, rp ? 4'b0100 : 4'b0000);
      if (j == 27) KEY[2] = 1'b1;
    end
    chk("repeat pulse count", 4'(rep_cnt), 4'd7);
    chk("step pulse count", 4'(step_cnt), 4'd8);

    // Repeat disable: enable drops at +12, returns at +20 -> pulses +10 and +30.
    KEY[2] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_all($sformatf("dis press k=%0d", k), (k >= 6) ? 4'b0100 : 4'b0000,
              (k == 6) ? 4'b0100 : 4'b0000, 4'h0, 4'h0, (k == 6) ? 4'b0100 : 4'b0000);
    end
    for (int j = 1; j <= 37; j++) begin
      logic rp;
      tick();
      rp = (j == 10) || (j == 30);
      chk_all($sformatf("disable j=%0d", j), (j < 35) ? 4'b0100 : 4'b0000, 4'h0,
              (j == 35) ? 4'b0100 : 4'b0000, rp ? 4'b0100 : 4'b0000, rp ? 4'b0100 : 4'b0000);
      if (j == 12) REPEAT_EN = 4'b0000;
      if (j == 20) REPEAT_EN = 4'b0100;
      if (j == 29) KEY[2] = 1'b1;
    end

    // Reset during CONFIRM_PRESS and during HELD on key 3.
    REPEAT_EN = 4'b0000;
    KEY[3] = 1'b0;
    tick();
    tick();
    tick();
    tick();
    RST = 1'b1;
    #1;
    chk_all("rst confirm", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    tick();
    RST = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_all($sformatf("after rst1 k=%0d", k), (k >= 6) ? 4'b1000 : 4'b0000,
              (k == 6) ? 4'b1000 : 4'b0000, 4'h0, 4'h0, (k == 6) ? 4'b1000 : 4'b0000);
    end
    RST = 1'b1;
    #1;
    chk_all("rst held", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    tick();
    RST = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_all($sformatf("after rst2 k=%0d", k), (k >= 6) ? 4'b1000 : 4'b0000,
              (k == 6) ? 4'b1000 : 4'b0000, 4'h0, 4'h0, (k == 6) ? 4'b1000 : 4'b0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
